seq_mul_param: RTL and testbench
================================

Name: seq_mul_param

Overview:
Parametrised shift-add sequential multiplier; next generation of the fixed 8-bit seq_mul. Adds an explicit start/busy/done handshake, operand capture, result hold and back-to-back operation. Sits beside the ALU datapath as a multi-cycle multiply unit: one partial product is processed per clock, with an add-then-shift-right into a 2*WIDTH accumulator.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH), step counter width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled each rising edge, accepted only in IDLE or DONE
a  input  WIDTH  multiplicand; captured on the accepting edge
b  input  WIDTH  multiplier; captured on the accepting edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; prod valid from this cycle onward
prod  output  2*WIDTH  registered product; holds until the next completion

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset, sampled at a clk edge: state=IDLE, busy=0, done=0, prod=0, accumulator=0, counter=0. Reset takes priority over every other event.
- States and transitions:
  - IDLE: waits for start. On start=1: mcand<=a, acc<={WIDTH'b0,b}, cnt<=0, go to RUN.
  - RUN: each cycle, if acc[0]=1 then {c,s}=acc[2W-1:W]+mcand, else {c,s}={0,acc[2W-1:W]}. Then acc<={c,s,acc[W-1:1]} and cnt<=cnt+1. When cnt==WIDTH-1, this step is the last: prod<=the shifted value, go to DONE.
  - DONE: done=1 for exactly this cycle. If start=1, accept new operands as in IDLE and go to RUN (back-to-back). Otherwise go to IDLE.
- busy and done are decoded from registered state; they are never high together.
- Latency: start sampled at edge 0 -> RUN cycles 1..WIDTH -> done=1 in cycle WIDTH+1. Throughput: one product per WIDTH+1 cycles.
- Start during RUN is ignored; operands are not re-captured and there is no error flag.
- a and b may change freely after the accepting edge; only captured copies are used.
- prod changes only on the edge that enters DONE. It keeps the last result through IDLE and the next RUN.
- Reset asserted mid-RUN aborts the operation. prod is cleared to 0 and no done pulse is issued.
- Arithmetic: unsigned, exact, modulo-free. The carry out of each add is kept as accumulator bit 2W-1, so no overflow is possible.

Optional Feature:
SEQ_MUL_SIGNED_EN
- Defined: adds input port sgn (1 bit), captured with a and b.
  - sgn=0: unsigned behaviour, unchanged.
  - sgn=1: operands are two's complement. Each add sign-extends to W+1 bits, and the shift-in bit is the sign bit of the W+1-bit sum, not the carry.
  - On the final step (cnt==WIDTH-1) with acc[0]=1, mcand is subtracted instead of added.
  - prod is the exact 2W-bit two's-complement product. Latency is unchanged.
- Not defined: no sgn port; unsigned only.

Test Plan:
- WIDTH=8, reset, then start with a=13, b=11 -> busy high for cycles 1-8; done pulse in cycle 9; prod=143 (0x008F); prod holds for 20 idle cycles.
- WIDTH=8, a=255, b=255 -> prod=65025 (0xFE01). Then a=0, b=0xA5 -> prod=0. Then a=1, b=0x80 -> prod=0x0080.
- Back-to-back: start held high continuously with a=3, b=7, then a=6, b=9 presented in the DONE cycle -> done in cycles 9 and 18; prod=21 then 54; busy low only in the DONE cycles.
- Start pulses during RUN with different operands -> ignored. Assert reset in RUN cycle 4 -> busy=0, done never pulses, prod=0. A new start after reset completes correctly.
- WIDTH=16, a=0xFFFF, b=0xFFFF -> done in cycle 17; prod=0xFFFE0001.
- SEQ_MUL_SIGNED_EN, WIDTH=8:
  - sgn=1, a=-3, b=5 -> prod=0xFFF1.
  - sgn=1, a=-128, b=-128 -> prod=0x4000.
  - sgn=1, a=127, b=-1 -> prod=0xFF81.
  - sgn=0, a=0xFD, b=5 -> prod=0x04F1.

Source files
------------

// File: rtl/seq_mul_param_if.sv
// Start/busy/done handshake bundle for the seq_mul_param shift-add multiplier.
// SEQ_MUL_SIGNED_EN adds the sgn operand qualifier.
interface seq_mul_param_if #(
   parameter int unsigned WIDTH = 8
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
`ifdef SEQ_MUL_SIGNED_EN
   logic                 sgn;
`endif
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   prod;

`ifdef SEQ_MUL_SIGNED_EN
   modport master (output start, a, b, sgn, input busy, done, prod);
   modport slave  (input start, a, b, sgn, output busy, done, prod);
`else
   modport master (output start, a, b, input busy, done, prod);
   modport slave  (input start, a, b, output busy, done, prod);
`endif
endinterface

// File: rtl/seq_mul_param.sv
// Parametrised shift-add sequential multiplier, one partial product per clock.
// Optional SEQ_MUL_SIGNED_EN enables two's-complement operation via bus.sgn.
module seq_mul_param #(
   parameter int unsigned WIDTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   seq_mul_param_if.slave bus
);
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned PW    = 2 * WIDTH;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

   state_e            state_q, state_n;
   logic [PW-1:0]     acc_q, acc_n;
   logic [PW-1:0]     prod_q, prod_n;
   logic [WIDTH-1:0]  mcand_q, mcand_n;
   logic [CNT_W-1:0]  cnt_q, cnt_n;
   logic              busy_q, done_q;
   logic              sgn_act;
   logic              last;
   logic [WIDTH:0]    hi_ext, md_ext, sum;
   logic [PW-1:0]     shifted;

`ifdef SEQ_MUL_SIGNED_EN
   logic sgn_q, sgn_n;
   assign sgn_act = sgn_q;
`else
   assign sgn_act = 1'b0;
`endif

   // One step: add (or subtract on the signed final step), then shift right.
   always_comb begin
      last    = (cnt_q == LAST);
      hi_ext  = {sgn_act & acc_q[PW-1], acc_q[PW-1:WIDTH]};
      md_ext  = acc_q[0] ? {sgn_act & mcand_q[WIDTH-1], mcand_q} : '0;
      sum     = (sgn_act && last) ? (hi_ext - md_ext) : (hi_ext + md_ext);
      shifted = {sum, acc_q[WIDTH-1:1]};
   end

   always_comb begin
      state_n = state_q;
      acc_n   = acc_q;
      prod_n  = prod_q;
      mcand_n = mcand_q;
      cnt_n   = cnt_q;
`ifdef SEQ_MUL_SIGNED_EN
      sgn_n   = sgn_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               mcand_n = bus.a;
               acc_n   = {WIDTH'(0), bus.b};
               cnt_n   = '0;
`ifdef SEQ_MUL_SIGNED_EN
               sgn_n   = bus.sgn;
`endif
               state_n = RUN;
            end else begin
               state_n = IDLE;
            end
         end
         RUN: begin
            acc_n = shifted;
            cnt_n = cnt_q + CNT_W'(1);
            if (last) begin
               prod_n  = shifted;
               state_n = DONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // busy/done are registered from the next state so they align with state_q.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         prod_q  <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
         sgn_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_n;
         acc_q   <= acc_n;
         prod_q  <= prod_n;
         mcand_q <= mcand_n;
         cnt_q   <= cnt_n;
         busy_q  <= (state_n == RUN);
         done_q  <= (state_n == DONE);
`ifdef SEQ_MUL_SIGNED_EN
         sgn_q   <= sgn_n;
`endif
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.prod = prod_q;
endmodule

// File: tb/tb_seq_mul_param.sv
// Scoreboard bench for seq_mul_param (WIDTH=8 main instance, WIDTH=16 spot checks).
// Honours SEQ_MUL_SIGNED_EN for the signed test vectors.
module tb_seq_mul_param;
   localparam int unsigned W = 8;

   typedef struct {
      logic [2*W-1:0] prod;
      int             due;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rst_smp = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q[$];
   logic [2*W-1:0] hold = '0;
   int   run_len = 0;

   seq_mul_param_if #(.WIDTH(W))  i8 ();
   seq_mul_param_if #(.WIDTH(16)) i16 ();

   seq_mul_param #(.WIDTH(W))  u8  (.clk(clk), .reset(reset), .bus(i8));
   seq_mul_param #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .bus(i16));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rst_smp <= reset;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: exact product of the (optionally sign-extended) operands.
   function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
      logic [2*W-1:0] ea, eb;
      ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
      eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
      return ea * eb;
   endfunction

   // Monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (rst_smp) begin
         check("reset_busy", 32'(i8.busy), 32'd0);
         check("reset_done", 32'(i8.done), 32'd0);
         check("reset_prod", 32'(i8.prod), 32'd0);
         q.delete();
         hold    = '0;
         run_len = 0;
      end else begin
         if (i8.busy && i8.done) check("busy_and_done", 32'd1, 32'd0);
         if (i8.done) begin
            if (q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("prod", 32'(i8.prod), 32'(e.prod));
               check("latency", 32'(cyc), 32'(e.due));
               check("run_len", 32'(run_len), 32'(W));
               hold = e.prod;
            end
         end else begin
            check("prod_hold", 32'(i8.prod), 32'(hold));
         end
         run_len = i8.busy ? run_len + 1 : 0;
      end
   end

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [2*W-1:0] exp, input bit use_model, input bit keep);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk);
      while (i8.busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("wait_idle_timeout", 32'd1, 32'd0);
      i8.a     = a;
      i8.b     = b;
`ifdef SEQ_MUL_SIGNED_EN
      i8.sgn   = s;
`endif
      i8.start = 1'b1;
      @(posedge clk);
      #1;
      e.prod = use_model ? model(a, b, s) : exp;
      e.due  = cyc + W;
      q.push_back(e);
      if (!keep) i8.start = 1'b0;
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rs;
      int          c0;
      int          n;
      i8.start  = 1'b0;
      i8.a      = '0;
      i8.b      = '0;
      i16.start = 1'b0;
      i16.a     = '0;
      i16.b     = '0;
`ifdef SEQ_MUL_SIGNED_EN
      i8.sgn    = 1'b0;
      i16.sgn   = 1'b0;
`endif
      repeat (3) @(negedge clk);
      reset = 1'b0;

      run_op(8'd13, 8'd11, 1'b0, 16'd143, 1'b0, 1'b0);
      repeat (30) @(negedge clk);
      run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, 1'b0);
      run_op(8'h00, 8'hA5, 1'b0, 16'h0000, 1'b0, 1'b0);
      run_op(8'h01, 8'h80, 1'b0, 16'h0080, 1'b0, 1'b0);

      // Back-to-back with start held high.
      run_op(8'd3, 8'd7, 1'b0, 16'd21, 1'b0, 1'b1);
      run_op(8'd6, 8'd9, 1'b0, 16'd54, 1'b0, 1'b0);

      // Start during RUN must be ignored.
      run_op(8'd37, 8'd41, 1'b0, 16'd1517, 1'b0, 1'b0);
      repeat (2) begin
         @(negedge clk);
         i8.start = 1'b1;
         i8.a     = 8'($urandom);
         i8.b     = 8'($urandom);
      end
      @(negedge clk);
      i8.start = 1'b0;

      // Reset mid-RUN aborts: no done, prod cleared.
      run_op(8'd200, 8'd199, 1'b0, 16'd39800, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      run_op(8'd17, 8'd19, 1'b0, 16'd323, 1'b0, 1'b0);

`ifdef SEQ_MUL_SIGNED_EN
      run_op(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0, 1'b0);
      run_op(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0, 1'b0);
      run_op(8'h7F, 8'hFF, 1'b1, 16'hFF81, 1'b0, 1'b0);
      run_op(8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b0, 1'b0);
`endif

      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
`ifdef SEQ_MUL_SIGNED_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         run_op(ra[7:0], rb[7:0], rs, '0, 1'b1, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 0) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      @(negedge clk);
      i8.start = 1'b0;

      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);

      // WIDTH=16 instance: directed corner plus a few random products.
      for (int i = 0; i < 4; i++) begin
         ra = (i == 0) ? 16'hFFFF : 16'($urandom);
         rb = (i == 0) ? 16'hFFFF : 16'($urandom);
         @(negedge clk);
         i16.a     = ra;
         i16.b     = rb;
         i16.start = 1'b1;
         @(posedge clk);
         #1;
         c0 = cyc;
         i16.start = 1'b0;
         n = 0;
         @(negedge clk);
         while (!i16.done && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("w16_done_seen", 32'(i16.done), 32'd1);
         check("w16_latency", 32'(cyc - c0), 32'd16);
         check("w16_prod", i16.prod, (i == 0) ? 32'hFFFE0001 : ({16'd0, ra} * {16'd0, rb}));
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
